// File: rtl/seq_adder.sv
// seq_adder: multi-cycle WIDTH-bit adder/subtractor that processes DIGIT
// bits per clock. It uses a start/busy/done handshake. The result and flags
// are registered and change only when an operation completes.
//
// Parameters:
//   WIDTH - operand/result width (>= 2)
//   DIGIT - bits processed per clock; must divide WIDTH
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   x, y   in   operands (unsigned or two's complement)
//   cin    in   carry-in (borrow-in when subtracting)
//   sub    in   0 = add, 1 = subtract
//   busy   out  operation in progress
//   done   out  one-cycle pulse when res and the flags update
//   res    out  result
//   cout   out  carry out of the MSB (1 = no borrow when subtracting)
//   ovf    out  signed overflow
//   zero   out  res == 0
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last;

  // Digit adder. The carry into the top bit of a digit is recovered as
  // a ^ b ^ sum on that bit. On the final digit, this is the carry into bit
  // WIDTH-1, which the overflow flag needs.
  always_comb begin
    dsum    = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    msb_cin = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ dsum[DIGIT-1];
    last    = (cnt == CW'(STEPS - 1));
  end

  // New digits enter at the MSB end. After STEPS shifts, the whole result
  // is in place.
  if (DIGIT < WIDTH) begin : g_shift
    assign acc_next = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign acc_next = dsum[DIGIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      res   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is performed as x + ~y + 1. A borrow-in
            // cancels the +1.
            a_reg <= x;
            b_reg <= y ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            res  <= acc_next;
            cout <= dsum[DIGIT];
            ovf  <= msb_cin ^ dsum[DIGIT];
            zero <= (acc_next == '0);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed self-checking bench for seq_adder.
// It drives an 8-bit DIGIT=1 instance with directed tests. It also runs
// 4-bit instances (DIGIT = 1, 2, 4) through an exhaustive sweep against a
// behavioural model.
module tb_seq_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] res;
  logic       cout;
  logic       ovf;
  logic       zero;

  logic       start4;
  logic [3:0] x4;
  logic [3:0] y4;
  logic       cin4;
  logic       sub4;
  logic [2:0] busy4;
  logic [2:0] done4;
  logic [3:0] res4 [3];
  logic [2:0] cout4;
  logic [2:0] ovf4;
  logic [2:0] zero4;

  int errors;
  int checks;

  seq_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .cin(cin),
    .sub(sub), .busy(busy), .done(done), .res(res), .cout(cout),
    .ovf(ovf), .zero(zero)
  );

  seq_adder #(.WIDTH(4), .DIGIT(1)) dut4_d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .cin(cin4),
    .sub(sub4), .busy(busy4[0]), .done(done4[0]), .res(res4[0]),
    .cout(cout4[0]), .ovf(ovf4[0]), .zero(zero4[0])
  );

  seq_adder #(.WIDTH(4), .DIGIT(2)) dut4_d2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .cin(cin4),
    .sub(sub4), .busy(busy4[1]), .done(done4[1]), .res(res4[1]),
    .cout(cout4[1]), .ovf(ovf4[1]), .zero(zero4[1])
  );

  seq_adder #(.WIDTH(4), .DIGIT(4)) dut4_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .cin(cin4),
    .sub(sub4), .busy(busy4[2]), .done(done4[2]), .res(res4[2]),
    .cout(cout4[2]), .ovf(ovf4[2]), .zero(zero4[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model for 4-bit operations. The result is packed as
  // {cout, ovf, zero, res}.
  function automatic logic [6:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c, input logic s);
    logic [3:0] bb;
    logic [4:0] full;
    logic       v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {4'b0000, c ^ s};
    v    = (a[3] == bb[3]) && (full[3] != a[3]);
    return {full[4], v, (full[3:0] == 4'd0), full[3:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    start4 = 1'b0; x4 = '0; y4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    checks++;
    if ({res, cout, ovf, zero} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 000", {res, cout, ovf, zero});
    end
    checks++;
    if ({busy4, done4} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_4bit: got %b expected 000000", {busy4, done4});
    end
    rst_n = 1'b1;
  endtask

  // Runs one 8-bit operation and checks latency, busy length, output hold,
  // the result and flags, and that done is a single-cycle pulse.
  task automatic test_op8(input logic [7:0] xa, input logic [7:0] ya,
                          input logic ci, input logic sb,
                          input logic [7:0] eres, input logic ecout,
                          input logic eovf, input logic ezero,
                          input logic [7:0] prev_res, input string name);
    int   busy_cycles;
    int   done_n;
    logic partial;
    busy_cycles = 0; done_n = 0; partial = 1'b0;
    @(negedge clk);
    x = xa; y = ya; cin = ci; sub = sb; start = 1'b1;
    for (int n = 1; n <= 20 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) done_n = n;
      else if (res !== prev_res) partial = 1'b1;
    end
    checks++;
    if (done_n - 1 != 8) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d expected 8", name, done_n - 1);
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d expected 8", name, busy_cycles);
    end
    checks++;
    if (partial) begin
      errors++;
      $display("[TB] FAIL %s_hold: res changed before done, expected %h held", name, prev_res);
    end
    checks++;
    if ({res, cout, ovf, zero} !== {eres, ecout, eovf, ezero}) begin
      errors++;
      $display("[TB] FAIL %s_result: got res=%h c=%b v=%b z=%b expected res=%h c=%b v=%b z=%b",
               name, res, cout, ovf, zero, eres, ecout, eovf, ezero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse: got %b expected 0", name, done);
    end
  endtask

  task automatic test_ignore_start();
    int         dones;
    int         done_n;
    logic [7:0] got;
    dones = 0; done_n = 0; got = '0;
    @(negedge clk);
    x = 8'h12; y = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin x = 8'hFF; y = 8'hFF; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (done) begin dones++; done_n = n; got = res; end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones);
    end
    checks++;
    if (got !== 8'h46) begin
      errors++;
      $display("[TB] FAIL ignore_result: got %h expected 46", got);
    end
    checks++;
    if (done_n != 9) begin
      errors++;
      $display("[TB] FAIL ignore_done_cycle: got %0d expected 9", done_n);
    end
  endtask

  // start is held high and x changes at each done. Each result must
  // reflect the x present at its own accepting edge.
  task automatic test_back_to_back();
    int         dones;
    int         pos [4];
    logic [7:0] got [4];
    logic [7:0] exp_res [4];
    exp_res = '{8'h03, 8'h12, 8'h22, 8'h32};
    dones = 0;
    for (int k = 0; k < 4; k++) begin pos[k] = 0; got[k] = '0; end
    @(negedge clk);
    x = 8'h01; y = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        if (dones < 4) begin pos[dones] = n; got[dones] = res; end
        dones++;
        if (dones < 4) x = 8'(dones * 16);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 4", dones);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pos[k] != 9 * (k + 1)) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got %0d expected %0d", k, pos[k], 9 * (k + 1));
      end
      checks++;
      if (got[k] !== exp_res[k]) begin
        errors++;
        $display("[TB] FAIL b2b_result%0d: got %h expected %h", k, got[k], exp_res[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    extra = 0;
    @(negedge clk);
    x = 8'h05; y = 8'h06; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_busy_done: got %b expected 00", {busy, done});
    end
    checks++;
    if ({res, cout, ovf, zero} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h expected 000", {res, cout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", extra);
    end
    test_op8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, "after_reset");
  endtask

  task automatic test_sweep4();
    int         lat [3];
    int         dn [3];
    logic [6:0] cap [3];
    logic [6:0] expv;
    lat = '{4, 2, 1};
    for (int xs = 0; xs < 16; xs++) begin
      for (int ys = 0; ys < 16; ys++) begin
        for (int cs = 0; cs < 4; cs++) begin
          @(negedge clk);
          x4 = 4'(xs); y4 = 4'(ys); cin4 = cs[0]; sub4 = cs[1]; start4 = 1'b1;
          for (int i = 0; i < 3; i++) begin dn[i] = 0; cap[i] = 7'bx; end
          expv = model4(4'(xs), 4'(ys), cs[0], cs[1]);
          for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
              start4 = 1'b0;
              checks++;
              if (busy4 !== 3'b111) begin
                errors++;
                $display("[TB] FAIL sweep_busy x=%h y=%h c=%b s=%b: got %b expected 111",
                         4'(xs), 4'(ys), cs[0], cs[1], busy4);
              end
            end
            for (int i = 0; i < 3; i++) begin
              if (done4[i]) begin
                dn[i]  = (dn[i] == 0) ? n : 99;
                cap[i] = {cout4[i], ovf4[i], zero4[i], res4[i]};
              end
            end
          end
          for (int i = 0; i < 3; i++) begin
            checks++;
            if (dn[i] != lat[i] + 1) begin
              errors++;
              $display("[TB] FAIL sweep_latency d%0d x=%h y=%h c=%b s=%b: got %0d expected %0d",
                       lat[i] == 4 ? 1 : (lat[i] == 2 ? 2 : 4), 4'(xs), 4'(ys), cs[0], cs[1],
                       dn[i] - 1, lat[i]);
            end
            checks++;
            if (cap[i] !== expv) begin
              errors++;
              $display("[TB] FAIL sweep_result d%0d x=%h y=%h c=%b s=%b: got %b expected %b",
                       lat[i] == 4 ? 1 : (lat[i] == 2 ? 2 : 4), 4'(xs), 4'(ys), cs[0], cs[1],
                       cap[i], expv);
            end
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 8'h00, "add_5a_3c");
    test_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h96, "add_ff_01");
    test_op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, "sub_10_20");
    test_op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 8'hF0, "sub_80_01");
    test_op8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 8'h7F, "sbb_80_01");
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor for the toy processor datapath. It generalises the single-bit full adder into a WIDTH-bit operation that processes DIGIT bits per clock, carrying between digits in an internal carry register. It uses a START/BUSY/DONE handshake so the ALU control FSM can trade area for latency. It produces the result together with carry, signed-overflow and zero flags.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per clock; must divide WIDTH evenly. STEPS = WIDTH/DIGIT.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- X  in  WIDTH  operand A, unsigned or two's complement.
- Y  in  WIDTH  operand B.
- CIN  in  1  carry-in.
- SUB  in  1  0 = add, 1 = subtract.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse when RES and the flags update.
- RES  out  WIDTH  result.
- COUT  out  1  carry out of the MSB (for subtract, 1 = no borrow).
- OVF  out  1  signed overflow.
- ZERO  out  1  RES == 0.

## Operation
- Two states: IDLE and RUN. There is also a step counter of ceil(log2(STEPS)) bits, at least 1 bit.
- IDLE → RUN when START = 1 at a clock edge. That edge performs these actions:
  - latches X into the operand-A register;
  - latches Y XOR {WIDTH{SUB}} into the operand-B register;
  - loads the carry register with CIN XOR SUB;
  - clears the step counter.
- In RUN, each edge performs these actions:
  - adds the low DIGIT bits of both operand registers plus the carry register;
  - shifts the DIGIT-bit sum into the MSB end of an internal result shift register;
  - shifts both operand registers right by DIGIT;
  - updates the carry register;
  - increments the counter.
- On the edge that processes digit STEPS-1:
  - RES ← final shift-register contents;
  - COUT ← carry out of bit WIDTH-1;
  - OVF ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - ZERO ← (final result == 0);
  - DONE ← 1 for exactly one cycle;
  - the state returns to IDLE.
- SUB = 1, CIN = 0 gives X − Y. SUB = 1, CIN = 1 gives X − Y − 1 (borrow-in).
- RES, COUT, OVF and ZERO hold their last completed values and never show partial results. They change only on the completion edge.
- START while BUSY = 1 is ignored, with no queueing. X, Y, CIN and SUB may change freely after the accepting edge.
- Reset at any time, including mid-RUN, performs these actions:
  - state = IDLE, counter = 0;
  - all internal registers cleared;
  - BUSY = 0, DONE = 0, RES = 0, COUT = 0, OVF = 0, ZERO = 0;
  - no completion is reported for the aborted operation.

## Timing
- Label the accepting edge E0. BUSY is high from just after E0 until E_STEPS, and low after E_STEPS.
- DONE and the updated outputs are valid in the cycle after E_STEPS. Latency is STEPS cycles from START sample to DONE.
- Back-to-back: START high in the DONE cycle is accepted at E_STEPS+1, so the throughput is one result per STEPS+1 cycles.
- DIGIT = WIDTH (STEPS = 1): BUSY is high for one cycle, and DONE follows one cycle after START.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=1, X=0x5A, Y=0x3C, CIN=0, SUB=0, START pulse → after 8 edges DONE=1 for one cycle, RES=0x96, COUT=0, OVF=1, ZERO=0. BUSY is high for exactly 8 cycles.
- X=0xFF, Y=0x01, CIN=0, SUB=0 → RES=0x00, COUT=1, OVF=0, ZERO=1. Then X=0x10, Y=0x20, SUB=1 → RES=0xF0, COUT=0, OVF=0.
- X=0x80, Y=0x01, SUB=1, CIN=0 → RES=0x7F, COUT=1, OVF=1. Repeat with CIN=1 → RES=0x7E.
- Start 0x12+0x34. Pulse START with 0xFF+0xFF at cycle 3 → only RES=0x46 is reported, once. Drive START held high → results come back-to-back, with DONE every 9 cycles.
- Start an operation and assert RST_N=0 mid-RUN at cycle 4 → outputs are 0 immediately, BUSY=0, and no DONE follows. After release, a new START completes normally.
- WIDTH=4, DIGIT ∈ {1, 2, 4}: exhaustive sweep of all X, Y, CIN and SUB (1024 cases) against a reference model. Latency must be 4, 2 and 1 cycles respectively.
